// File: rtl/tx_sched_pkg.sv
// Shared constants, state encoding and frame-length helpers for the
// transmit frame scheduler.
package tx_sched_pkg;

    localparam int DEF_HEAD_CYCLES  = 136;
    localparam int DEF_LENGTH_BYTES = 16;
    localparam int DEF_N_DBPS       = 24;
    localparam int DEF_IFS_CYCLES   = 4;
    localparam int CNT_W            = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_HEAD  = 3'd2;
    localparam logic [2:0] ST_PSDU  = 3'd3;
    localparam logic [2:0] ST_TRAIL = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    // Tail bits plus pad up to the end of the last OFDM symbol, plus one settle cycle.
    function automatic int trail_cycles(input int lengthBytes, input int nDbps);
        int r;
        r = ((16 + 8 * lengthBytes + 7 - 1) % nDbps) + 1;
        return 7 + (nDbps - r) + 1;
    endfunction

    function automatic int frame_cycles(input int headCycles, input int lengthBytes,
                                        input int nDbps, input int ifsCycles);
        return 1 + headCycles + 8 * lengthBytes + trail_cycles(lengthBytes, nDbps)
               + ifsCycles + 1;
    endfunction

    localparam int TRAIL_CYCLES = trail_cycles(DEF_LENGTH_BYTES, DEF_N_DBPS);
    localparam int FRAME_CYCLES = frame_cycles(DEF_HEAD_CYCLES, DEF_LENGTH_BYTES,
                                               DEF_N_DBPS, DEF_IFS_CYCLES);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after the pointer,
// wrapping modulo N, returned as one-hot grant plus index.
module rr_arbiter
    import tx_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int off = 1; off <= N; off++) begin
            if (!valid_o && req_i[(int'(ptr_i) + off) % N]) begin
                valid_o                            = 1'b1;
                grant_o[(int'(ptr_i) + off) % N]   = 1'b1;
                idx_o                              = IDX_W'((int'(ptr_i) + off) % N);
            end
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Round-robin owner of a shared 802.11a transmitter: issues Start, serialises
// the owner's PSDU bytes LSB-first in the sampled cycles, then enforces the gap.
module tx_frame_scheduler
    import tx_sched_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int LENGTH_BYTES = DEF_LENGTH_BYTES,
    parameter int N_DBPS       = DEF_N_DBPS,
    parameter int HEAD_CYCLES  = DEF_HEAD_CYCLES,
    parameter int IFS_CYCLES   = DEF_IFS_CYCLES
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [N_REQ-1:0]   Request,
    input  logic [8*N_REQ-1:0] ByteIn,
    output logic [N_REQ-1:0]   Grant,
    output logic [N_REQ-1:0]   ByteAck,
    output logic               TxStart,
    output logic               TxInput,
    output logic               Busy,
    output logic               FrameDone
);

    localparam int IDX_W     = $clog2(N_REQ);
    localparam int TRAIL_LEN = trail_cycles(LENGTH_BYTES, N_DBPS);

    localparam logic [CNT_W-1:0] HEAD_LAST  = CNT_W'(HEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HEAD_ACK   = CNT_W'(HEAD_CYCLES - 2);
    localparam logic [CNT_W-1:0] PSDU_LAST  = CNT_W'(8 * LENGTH_BYTES - 1);
    localparam logic [CNT_W-1:0] TRAIL_LAST = CNT_W'(TRAIL_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IFS_CYCLES - 1);
    localparam logic [CNT_W-4:0] LAST_BYTE  = (CNT_W - 3)'(LENGTH_BYTES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [7:0]       shreg_q;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             start_q, start_d;
    logic             txin_q, txin_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ackNext;
    logic [7:0]       laneByte;

    logic [N_REQ-1:0] arbGrant;
    logic [IDX_W-1:0] arbIdx;
    logic             arbValid;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (Request),
        .ptr_i   (ptr_q),
        .grant_o (arbGrant),
        .idx_o   (arbIdx),
        .valid_o (arbValid)
    );

    // ptr_q doubles as the owner index while a frame is in flight.
    always_comb begin
        laneByte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ptr_q == IDX_W'(i)) laneByte = ByteIn[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (arbValid) begin
                    state_d = ST_START;
                    grant_d = arbGrant;
                    ptr_d   = arbIdx;
                end
            end
            ST_START: begin
                state_d = ST_HEAD;
                cnt_d   = '0;
            end
            ST_HEAD: begin
                if (cnt_q == HEAD_LAST) begin
                    state_d = ST_PSDU;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PSDU: begin
                if (cnt_q == PSDU_LAST) begin
                    state_d = ST_TRAIL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_TRAIL: begin
                if (cnt_q == TRAIL_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    grant_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                grant_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they land in the same cycle as it.
    // The bit for the coming cycle is read from shreg_q before any reload takes effect.
    always_comb begin
        start_d = (state_d == ST_START);
        busy_d  = (state_d != ST_IDLE);
        txin_d  = (state_d == ST_PSDU) ? shreg_q[cnt_d[2:0]] : 1'b0;
        ackNext = ((state_d == ST_HEAD) && (cnt_d == HEAD_ACK)) ||
                  ((state_d == ST_PSDU) && (cnt_d[2:0] == 3'd6) &&
                   (cnt_d[CNT_W-1:3] != LAST_BYTE));
        ack_d   = ackNext ? grant_d : '0;
        done_d  = (state_d == ST_TRAIL) && (cnt_d == TRAIL_LAST);
    end

    // The lane is captured at the end of the cycle in which ByteAck is shown.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            shreg_q <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            txin_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            txin_q  <= txin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (|ack_q) shreg_q <= laneByte;
        end
    end

    assign Grant     = grant_q;
    assign ByteAck   = ack_q;
    assign TxStart   = start_q;
    assign TxInput   = txin_q;
    assign Busy      = busy_q;
    assign FrameDone = done_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Scoreboard bench: a phase-based reference model queues the expected outputs of
// every cycle and a monitor compares them; lane drivers react to ByteAck after 8 cycles.
module tb_tx_frame_scheduler;

    localparam int N     = 4;
    localparam int L     = 16;
    localparam int NDBPS = 24;
    localparam int HEAD  = 136;
    localparam int IFS   = 4;
    localparam int TRAIL = 8 + NDBPS - (((16 + 8 * L + 6) % NDBPS) + 1);
    localparam int BUSY_PHASES = 1 + HEAD + 8 * L + TRAIL + IFS;
    localparam int DONE_PHASE  = HEAD + 8 * L + TRAIL;
    localparam int DEPTH = 512;
    localparam int VW    = 2 * N + 4;

    logic             Clock   = 1'b0;
    logic             Reset   = 1'b0;
    logic [N-1:0]     Request = '0;
    logic [8*N-1:0]   ByteIn  = '0;
    logic [N-1:0]     Grant;
    logic [N-1:0]     ByteAck;
    logic             TxStart;
    logic             TxInput;
    logic             Busy;
    logic             FrameDone;

    tx_frame_scheduler #(
        .N_REQ        (N),
        .LENGTH_BYTES (L),
        .N_DBPS       (NDBPS),
        .HEAD_CYCLES  (HEAD),
        .IFS_CYCLES   (IFS)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Request   (Request),
        .ByteIn    (ByteIn),
        .Grant     (Grant),
        .ByteAck   (ByteAck),
        .TxStart   (TxStart),
        .TxInput   (TxInput),
        .Busy      (Busy),
        .FrameDone (FrameDone)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    logic [7:0]    laneData [N][DEPTH];
    int            lanePtr  [N];
    int            pend     [N];
    int            consumed [N];
    logic [VW-1:0] expQ [$];
    int            startCount = 0;
    int            ackCount   = 0;

    int mActive = 0;
    int mPhase  = 0;
    int mOwner  = 0;
    int mLast   = N - 1;
    int mBase   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic driveLanes();
        for (int i = 0; i < N; i++) ByteIn[8*i +: 8] = laneData[i][lanePtr[i] % DEPTH];
    endtask

    task automatic applyStimulus(input logic [N-1:0] req);
        @(posedge Clock);
        #1;
        Request = req;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic waitStarts(input int n, input int budget);
        int target;
        int k;
        target = startCount + n;
        k = 0;
        while (startCount < target && k < budget) begin
            @(posedge Clock);
            k++;
        end
        #1;
        if (startCount < target) checkOutput("startTimeout", 32'(startCount), 32'(target));
    endtask

    task automatic applyReset(input int holdCycles);
        Reset = 1'b0;
        expQ.delete();
        for (int i = 0; i < N; i++) begin
            pend[i]     = 0;
            lanePtr[i]  = 0;
            consumed[i] = 0;
        end
        driveLanes();
        #1;
        checkOutput("rstGrant",     32'(Grant),     32'(0));
        checkOutput("rstByteAck",   32'(ByteAck),   32'(0));
        checkOutput("rstTxStart",   32'(TxStart),   32'(0));
        checkOutput("rstTxInput",   32'(TxInput),   32'(0));
        checkOutput("rstBusy",      32'(Busy),      32'(0));
        checkOutput("rstFrameDone", 32'(FrameDone), 32'(0));
        repeat (holdCycles) @(posedge Clock);
        #2;
        Reset = 1'b1;
    endtask

    // Expected outputs for one cycle, from the frame phase counted since Start.
    function automatic logic [VW-1:0] modelVector();
        logic [N-1:0] g;
        logic [N-1:0] a;
        logic         st, ti, bz, dn;
        int           b;
        g = '0; a = '0; st = 1'b0; ti = 1'b0; bz = 1'b0; dn = 1'b0;
        if (mActive != 0) begin
            g[mOwner] = 1'b1;
            bz = 1'b1;
            st = (mPhase == 0);
            if (mPhase >= HEAD + 1 && mPhase <= HEAD + 8 * L) begin
                b  = mPhase - HEAD - 1;
                ti = laneData[mOwner][(mBase + b / 8) % DEPTH][b % 8];
            end
            if (mPhase == HEAD - 1 ||
                (mPhase >= HEAD + 7 && mPhase <= HEAD + 7 + 8 * (L - 2) &&
                 (mPhase - HEAD - 7) % 8 == 0))
                a[mOwner] = 1'b1;
            dn = (mPhase == DONE_PHASE);
        end
        return {g, a, st, ti, bz, dn};
    endfunction

    initial begin
        forever begin
            @(posedge Clock);
            if (!Reset) begin
                mActive = 0;
                mLast   = N - 1;
                expQ.delete();
            end else begin
                if (mActive == 0) begin
                    for (int off = 1; off <= N; off++) begin
                        if (mActive == 0 && Request[(mLast + off) % N]) begin
                            mActive = 1;
                            mOwner  = (mLast + off) % N;
                            mPhase  = 0;
                        end
                    end
                    if (mActive == 1) begin
                        mLast = mOwner;
                        mBase = consumed[mOwner];
                        consumed[mOwner] += L;
                    end
                end else begin
                    mPhase++;
                    if (mPhase >= BUSY_PHASES) mActive = 0;
                end
                expQ.push_back(modelVector());
            end
        end
    end

    initial begin
        logic [VW-1:0] e;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                if (TxStart) begin
                    startCount++;
                    ackCount = 0;
                end
                ackCount += $countones(ByteAck);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("outputs@%0t", $time),
                                32'({Grant, ByteAck, TxStart, TxInput, Busy, FrameDone}),
                                32'(e));
                end
                if (FrameDone) checkOutput("ackCount", 32'(ackCount), 32'(L));
            end
        end
    end

    // Each requester advances its lane 8 cycles after seeing its ByteAck.
    initial begin
        forever begin
            @(negedge Clock);
            for (int i = 0; i < N; i++) if (ByteAck[i]) pend[i] = 8;
            @(posedge Clock);
            #1;
            for (int i = 0; i < N; i++) begin
                if (pend[i] > 0) begin
                    pend[i]--;
                    if (pend[i] == 0) lanePtr[i]++;
                end
            end
            driveLanes();
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            lanePtr[i]  = 0;
            pend[i]     = 0;
            consumed[i] = 0;
            for (int k = 0; k < DEPTH; k++) laneData[i][k] = 8'($urandom);
        end
        for (int k = 0; k < L; k++) laneData[0][k] = 8'(k);
        driveLanes();

        #12;
        applyReset(3);

        applyStimulus(4'b0001);
        waitStarts(1, 20);
        applyStimulus(4'b0000);
        waitCycles(320);

        applyStimulus(4'b1111);
        waitStarts(5, 5 * 300 + 20);
        applyStimulus(4'b1000);
        waitStarts(1, 320);
        applyStimulus(4'b1010);
        waitStarts(2, 640);
        applyStimulus(4'b0000);
        waitCycles(320);

        applyStimulus(4'b0100);
        waitStarts(1, 20);
        waitCycles(48);
        applyStimulus(4'b0000);
        waitCycles(400);

        for (int r = 0; r < 12; r++) begin
            applyStimulus(N'($urandom_range(0, 15)));
            waitCycles($urandom_range(50, 400));
        end
        applyStimulus(4'b0000);
        waitCycles(600);

        applyStimulus(4'b0001);
        waitStarts(1, 20);
        applyStimulus(4'b0000);
        repeat (198) @(posedge Clock);
        #2;
        checkOutput("busyBeforeReset", 32'(Busy), 32'(1));
        applyReset(3);
        applyStimulus(4'b0101);
        waitStarts(1, 20);
        checkOutput("grantAfterReset", 32'(Grant), 32'(4'b0001));
        applyStimulus(4'b0000);
        waitCycles(320);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
